// File: rtl/alu_mc.sv
// Multi-cycle ALU. Logic ops, add/sub and compares finish in one cycle.
// MULTU uses shift-add and DIVU uses restoring division, one bit per cycle.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       ALUop,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             ovf,
    output logic             dz,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_MULTU = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_SLTS  = 3'b101;
    localparam logic [2:0] OP_SUB   = 3'b110;
    localparam logic [2:0] OP_SLT   = 3'b111;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] hi;
        logic             ovf;
        logic             dz;
    } res_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] p_hi;   // partial product high half / running remainder
    logic [WIDTH-1:0] p_lo;   // multiplier being shifted out / dividend -> quotient
    logic [WIDTH-1:0] opnd;   // multiplicand / divisor

    res_t             sc;
    logic [WIDTH-1:0] sum, dif;
    logic [WIDTH:0]   msum, rsh, rdiff;
    logic             ge, last;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n, div_hi_n, div_lo_n;

    always_comb begin
        sum = A + B;
        dif = A - B;
        sc  = '0;
        case (ALUop)
            OP_AND: sc.res = A & B;
            OP_OR:  sc.res = A | B;
            OP_ADD: begin
                sc.res = sum;
                sc.ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                sc.res = dif;
                sc.ovf = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT:  sc.res = {{(WIDTH-1){1'b0}}, A < B};
            OP_SLTS: sc.res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            // only reaches the output when B is zero
            OP_DIVU: begin
                sc.res = '1;
                sc.hi  = A;
                sc.dz  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        msum     = {1'b0, p_hi} + {1'b0, {WIDTH{p_lo[0]}} & opnd};
        mul_hi_n = msum[WIDTH:1];
        mul_lo_n = {msum[0], p_lo[WIDTH-1:1]};
        rsh      = {p_hi, p_lo[WIDTH-1]};
        rdiff    = rsh - {1'b0, opnd};
        ge       = rsh >= {1'b0, opnd};
        div_hi_n = ge ? rdiff[WIDTH-1:0] : rsh[WIDTH-1:0];
        div_lo_n = {p_lo[WIDTH-2:0], ge};
        last     = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            p_hi   <= '0;
            p_lo   <= '0;
            opnd   <= '0;
            result <= '0;
            hi     <= '0;
            zero   <= 1'b1;
            ovf    <= 1'b0;
            dz     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    state <= IDLE;
                    if (start) begin
                        if (ALUop == OP_MULTU || (ALUop == OP_DIVU && B != '0)) begin
                            state <= (ALUop == OP_MULTU) ? MUL : DIV;
                            busy  <= 1'b1;
                            cnt   <= '0;
                            p_hi  <= '0;
                            p_lo  <= A;
                            opnd  <= B;
                        end else begin
                            state  <= FIN;
                            done   <= 1'b1;
                            result <= sc.res;
                            hi     <= sc.hi;
                            zero   <= (sc.res == '0);
                            ovf    <= sc.ovf;
                            dz     <= sc.dz;
                        end
                    end
                end
                MUL: begin
                    p_hi <= mul_hi_n;
                    p_lo <= mul_lo_n;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        state  <= FIN;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        cnt    <= '0;
                        result <= mul_lo_n;
                        hi     <= mul_hi_n;
                        zero   <= (mul_lo_n == '0);
                        ovf    <= 1'b0;
                        dz     <= 1'b0;
                    end
                end
                DIV: begin
                    p_hi <= div_hi_n;
                    p_lo <= div_lo_n;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        state  <= FIN;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        cnt    <= '0;
                        result <= div_lo_n;
                        hi     <= div_hi_n;
                        zero   <= (div_lo_n == '0);
                        ovf    <= 1'b0;
                        dz     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: 32-bit and 8-bit instances, directed vector table,
// randomized ops against an arithmetic reference model, and corner sequences.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        st32 = 0, st8 = 0;
    logic [2:0]  op32 = 0, op8 = 0;
    logic [31:0] a32 = 0, b32 = 0, res32, hi32;
    logic [7:0]  a8 = 0, b8 = 0, res8, hi8;
    logic        z32, o32, d32, bz32, dn32;
    logic        z8, o8, d8, bz8, dn8;

    alu_mc #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .start(st32), .ALUop(op32), .A(a32), .B(b32),
        .result(res32), .hi(hi32), .zero(z32), .ovf(o32), .dz(d32), .busy(bz32), .done(dn32)
    );

    alu_mc #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .ALUop(op8), .A(a8), .B(b8),
        .result(res8), .hi(hi8), .zero(z8), .ovf(o8), .dz(d8), .busy(bz8), .done(dn8)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        string       name;
        bit          w8;
        logic [2:0]  op;
        logic [63:0] a, b, r, h;
        bit          z, o, d;
        int          lat;
    } vec_t;

    function automatic vec_t mk(string n, bit w8, logic [2:0] op, logic [63:0] a, logic [63:0] b,
                                logic [63:0] r, logic [63:0] h, bit z, bit o, bit d, int lat);
        vec_t v;
        v.name = n; v.w8 = w8; v.op = op; v.a = a; v.b = b;
        v.r = r; v.h = h; v.z = z; v.o = o; v.d = d; v.lat = lat;
        return v;
    endfunction

    // Reference built from plain integer arithmetic on the operand values.
    task automatic model(input bit w8, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] r, output logic [63:0] h,
                         output bit z, output bit o, output bit d, output int lat);
        int          w;
        logic [63:0] mask, p;
        longint      sa, sb, s, lim;
        w    = w8 ? 8 : 32;
        mask = w8 ? 64'hFF : 64'hFFFF_FFFF;
        lim  = w8 ? 128 : 64'd2147483648;
        sa   = (a >= lim) ? longint'(a) - 2 * lim : longint'(a);
        sb   = (b >= lim) ? longint'(b) - 2 * lim : longint'(b);
        r = 0; h = 0; o = 0; d = 0; lat = 1;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin s = sa + sb; r = (a + b) & mask; o = (s >= lim) || (s < -lim); end
            3'b110: begin s = sa - sb; r = (a - b) & mask; o = (s >= lim) || (s < -lim); end
            3'b111: r = (a < b) ? 1 : 0;
            3'b101: r = (sa < sb) ? 1 : 0;
            3'b011: begin p = a * b; r = p & mask; h = (p >> w) & mask; lat = w + 1; end
            default: begin
                if (b == 0) begin r = mask; h = a; d = 1; end
                else begin r = a / b; h = a % b; lat = w + 1; end
            end
        endcase
        z = (r == 0);
    endtask

    task automatic run_op(input bit w8, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] r, output logic [63:0] h,
                          output bit z, output bit o, output bit d, output int lat, output int bc);
        @(negedge clk);
        if (w8) begin op8 = op; a8 = a[7:0]; b8 = b[7:0]; st8 = 1; end
        else begin op32 = op; a32 = a[31:0]; b32 = b[31:0]; st32 = 1; end
        @(negedge clk);
        st8 = 0; st32 = 0;
        lat = 1; bc = 0;
        while (!(w8 ? dn8 : dn32) && lat < 200) begin
            if (w8 ? bz8 : bz32) bc++;
            @(negedge clk);
            lat++;
        end
        r = w8 ? {56'b0, res8} : {32'b0, res32};
        h = w8 ? {56'b0, hi8} : {32'b0, hi32};
        z = w8 ? z8 : z32;
        o = w8 ? o8 : o32;
        d = w8 ? d8 : d32;
    endtask

    vec_t vt[$];

    initial begin
        logic [63:0] r, h, er, eh, prev;
        bit          z, o, d, ez, eo, ed;
        int          lat, elat, bc, seen;

        vt.push_back(mk("add_ovf",  0, 3'b010, 32'h7FFFFFFF, 32'h1,        32'h80000000, 0,            0, 1, 0, 1));
        vt.push_back(mk("sub_zero", 0, 3'b110, 5,            5,            0,            0,            1, 0, 0, 1));
        vt.push_back(mk("slt",      0, 3'b111, 32'hFFFFFFFF, 1,            0,            0,            1, 0, 0, 1));
        vt.push_back(mk("slts",     0, 3'b101, 32'hFFFFFFFF, 1,            1,            0,            0, 0, 0, 1));
        vt.push_back(mk("multu",    0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1,            32'hFFFFFFFE, 0, 0, 0, 33));
        vt.push_back(mk("divu",     0, 3'b100, 100,          7,            14,           2,            0, 0, 0, 33));
        vt.push_back(mk("divz",     0, 3'b100, 9,            0,            32'hFFFFFFFF, 9,            0, 0, 1, 1));
        vt.push_back(mk("and",      0, 3'b000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 0,            0, 0, 0, 1));
        vt.push_back(mk("or",       0, 3'b001, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 0,            0, 0, 0, 1));
        vt.push_back(mk("sub_ovf",  0, 3'b110, 32'h80000000, 1,            32'h7FFFFFFF, 0,            0, 1, 0, 1));
        vt.push_back(mk("add_wrap", 0, 3'b010, 32'hFFFFFFFF, 1,            0,            0,            1, 0, 0, 1));
        vt.push_back(mk("mul_zero", 0, 3'b011, 0,            32'h12345,    0,            0,            1, 0, 0, 33));
        vt.push_back(mk("div_q0",   0, 3'b100, 5,            9,            0,            5,            1, 0, 0, 33));
        vt.push_back(mk("mul8",     1, 3'b011, 8'hFF,        8'hFF,        8'h01,        8'hFE,        0, 0, 0, 9));
        vt.push_back(mk("div8",     1, 3'b100, 100,          7,            14,           2,            0, 0, 0, 9));
        vt.push_back(mk("divz8",    1, 3'b100, 9,            0,            8'hFF,        9,            0, 0, 1, 1));
        vt.push_back(mk("add8",     1, 3'b010, 8'h7F,        1,            8'h80,        0,            0, 1, 0, 1));

        // reset values
        #12;
        chk("rst_res", res32, 0);  chk("rst_hi", hi32, 0);  chk("rst_zero", z32, 1);
        chk("rst_ovf", o32, 0);    chk("rst_dz", d32, 0);   chk("rst_busy", bz32, 0);
        chk("rst_done", dn32, 0);  chk("rst_zero8", z8, 1);
        @(negedge clk);
        rst_n = 1;

        foreach (vt[i]) begin
            run_op(vt[i].w8, vt[i].op, vt[i].a, vt[i].b, r, h, z, o, d, lat, bc);
            chk({vt[i].name, "_res"}, r, vt[i].r);
            chk({vt[i].name, "_hi"}, h, vt[i].h);
            chk({vt[i].name, "_zero"}, z, vt[i].z);
            chk({vt[i].name, "_ovf"}, o, vt[i].o);
            chk({vt[i].name, "_dz"}, d, vt[i].d);
            chk({vt[i].name, "_lat"}, lat, vt[i].lat);
            chk({vt[i].name, "_busy"}, bc, vt[i].lat - 1);
        end

        for (int i = 0; i < 40; i++) begin
            bit          w8;
            logic [2:0]  op;
            logic [63:0] a, b;
            w8 = 1'($urandom_range(0, 1));
            op = 3'($urandom_range(0, 7));
            a  = w8 ? 64'($urandom_range(0, 255)) : 64'($urandom);
            b  = w8 ? 64'($urandom_range(0, 255)) : 64'($urandom);
            if ($urandom_range(0, 7) == 0) b = 0;
            model(w8, op, a, b, er, eh, ez, eo, ed, elat);
            run_op(w8, op, a, b, r, h, z, o, d, lat, bc);
            chk($sformatf("rnd%0d_res", i), r, er);
            chk($sformatf("rnd%0d_hi", i), h, eh);
            chk($sformatf("rnd%0d_flags", i), {z, o, d}, {ez, eo, ed});
            chk($sformatf("rnd%0d_lat", i), lat, elat);
        end

        // start during MULTU iteration is ignored; outputs hold meanwhile
        prev = {32'b0, res32};
        @(negedge clk);
        op32 = 3'b011; a32 = 32'hFFFFFFFF; b32 = 32'hFFFFFFFF; st32 = 1;
        @(negedge clk);
        st32 = 0; lat = 1;
        repeat (4) begin @(negedge clk); lat++; end
        chk("hold_res", res32, prev);
        op32 = 3'b010; a32 = 1; b32 = 2; st32 = 1;
        @(negedge clk);
        st32 = 0; lat++;
        while (!dn32 && lat < 200) begin @(negedge clk); lat++; end
        chk("ign_lat", lat, 33);
        chk("ign_res", res32, 1);
        chk("ign_hi", hi32, 32'hFFFFFFFE);

        // back-to-back start in the FIN cycle
        op32 = 3'b010; a32 = 3; b32 = 4; st32 = 1;
        @(negedge clk);
        st32 = 0;
        chk("b2b_done", dn32, 1);
        chk("b2b_res", res32, 7);
        chk("b2b_hi", hi32, 0);

        // reset mid-DIVU aborts with no later done
        op32 = 3'b100; a32 = 100; b32 = 7; st32 = 1;
        @(negedge clk);
        st32 = 0;
        repeat (9) @(negedge clk);
        chk("mid_busy", bz32, 1);
        #2 rst_n = 0;
        #1;
        chk("arst_res", res32, 0); chk("arst_hi", hi32, 0); chk("arst_zero", z32, 1);
        chk("arst_busy", bz32, 0); chk("arst_done", dn32, 0); chk("arst_dz", d32, 0);
        @(negedge clk);
        rst_n = 1;
        seen = 0;
        repeat (40) begin @(negedge clk); if (dn32) seen++; end
        chk("no_done_after_abort", seen, 0);

        // first edge after release accepts a start
        rst_n = 0;
        @(negedge clk);
        rst_n = 1; op32 = 3'b010; a32 = 2; b32 = 2; st32 = 1;
        @(negedge clk);
        st32 = 0;
        chk("first_edge_done", dn32, 1);
        chk("first_edge_res", res32, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
